// File: rtl/freq_meter_autorange.sv
// Multi-channel frequency meter: per-channel BCD edge counters with
// auto-ranging gate time, and a multiplexed 7-segment display that scans
// out the latched result of the channel chosen by ch_sel.
module freq_meter_autorange #(
    parameter int CHANNELS = 2,
    parameter int DIGITS   = 4,
    parameter int GATE_CYC = 50000000,
    parameter int SCAN_DIV = 50000,
    parameter int CH_W     = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] clock_text,
    input  logic [CH_W-1:0]     ch_sel,
    output logic                valid,
    output logic [1:0]          range,
    output logic                overflow,
    output logic [DIGITS-1:0]   N,
    output logic [7:0]          L
);

    localparam int BW = 4 * DIGITS;
    localparam int TW = $clog2(GATE_CYC);
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [BW-1:0] ALL9 = {DIGITS{4'h9}};

    // Input conditioning
    logic [CHANNELS-1:0] s1, s2, s3;

    // Per-channel measurement state
    logic [TW-1:0]       timer   [CHANNELS];
    logic [1:0]          rng     [CHANNELS];
    logic [BW-1:0]       cnt     [CHANNELS];
    logic [BW-1:0]       res     [CHANNELS];
    logic [CHANNELS-1:0] ovf;
    logic [CHANNELS-1:0] res_ovf;

    // Per-channel next-state values
    logic [1:0]          rng_n   [CHANNELS];
    logic [BW-1:0]       cnt_n   [CHANNELS];
    logic [BW-1:0]       res_n   [CHANNELS];
    logic [CHANNELS-1:0] ovf_n;
    logic [CHANNELS-1:0] res_ovf_n;
    logic [CHANNELS-1:0] term;
    logic [CHANNELS-1:0] take;

    // Display state
    logic [SW-1:0] sel;
    logic [DW-1:0] div;
    logic [IW-1:0] idx;
    logic [3:0]    cur_digit;

    function automatic logic [TW-1:0] gate_last(input logic [1:0] r);
        case (r)
            2'd0:    return TW'(GATE_CYC - 1);
            2'd1:    return TW'(GATE_CYC / 10 - 1);
            default: return TW'(GATE_CYC / 100 - 1);
        endcase
    endfunction

    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (v[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Synchroniser chain; left unreset so an input already high when reset
    // releases is not mistaken for a fresh rising edge
    always_ff @(posedge clock) begin
        s1 <= clock_text;
        s2 <= s1;
        s3 <= s2;
    end

    // Edge counting, gate-close decision and range adjustment per channel
    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            cnt_n[c]     = cnt[c];
            ovf_n[c]     = ovf[c];
            rng_n[c]     = rng[c];
            res_n[c]     = res[c];
            res_ovf_n[c] = res_ovf[c];
            take[c]      = 1'b0;
            term[c]      = (timer[c] == gate_last(rng[c]));
            if (s2[c] && !s3[c]) begin
                if (cnt[c] == ALL9) ovf_n[c] = 1'b1;
                else                cnt_n[c] = bcd_inc(cnt[c]);
            end
            // the decision sees this cycle's edge, so a terminal-cycle edge
            // belongs to the closing gate
            if (term[c]) begin
                if (ovf_n[c] && rng[c] < 2'd2) begin
                    rng_n[c] = rng[c] + 2'd1;
                end else if (ovf_n[c]) begin
                    res_n[c]     = ALL9;
                    res_ovf_n[c] = 1'b1;
                    take[c]      = 1'b1;
                end else begin
                    res_n[c]     = cnt_n[c];
                    res_ovf_n[c] = 1'b0;
                    take[c]      = 1'b1;
                    if (cnt_n[c][BW-1 -: 4] == 4'd0 && rng[c] != 2'd0)
                        rng_n[c] = rng[c] - 2'd1;
                end
            end
        end
    end

    // Gate timers, counters and latched results; a new gate starts right
    // after the terminal cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf     <= '0;
            res_ovf <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                timer[c] <= '0;
                cnt[c]   <= '0;
                rng[c]   <= '0;
                res[c]   <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                timer[c] <= term[c] ? '0 : timer[c] + 1'b1;
                cnt[c]   <= term[c] ? '0 : cnt_n[c];
                ovf[c]   <= term[c] ? 1'b0 : ovf_n[c];
                rng[c]   <= rng_n[c];
                res[c]   <= res_n[c];
            end
            res_ovf <= res_ovf_n;
        end
    end

    // Channel select; out-of-range selections fall back to channel 0
    always_comb begin
        sel = '0;
        if (32'(ch_sel) < 32'(CHANNELS)) sel = SW'(ch_sel);
    end

    // Status outputs take the post-decision values so that range and
    // overflow already describe the result that valid announces
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid    <= 1'b0;
            range    <= 2'd0;
            overflow <= 1'b0;
        end else begin
            valid    <= take[sel];
            range    <= rng_n[sel];
            overflow <= res_ovf_n[sel];
        end
    end

    // Digit of the selected channel's latched result at the scan position
    always_comb begin
        cur_digit = 4'd0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (idx == IW'(d)) cur_digit = res[sel][4*d +: 4];
        end
    end

    // Scan divider, digit index and registered display drive
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div <= '0;
            idx <= '0;
            N   <= ~DIGITS'(1);
            L   <= 8'hC0;
        end else begin
            if (div == DW'(SCAN_DIV - 1)) begin
                div <= '0;
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                div <= div + 1'b1;
            end
            N <= ~(DIGITS'(1) << idx);
            L <= seg7(cur_digit);
        end
    end

endmodule

// File: tb/tb_freq_meter_autorange.sv
// Directed bench for freq_meter_autorange: expected results are queued when
// stimulus is applied and compared when the selected channel reports valid.
`timescale 1ns/1ps
module tb_freq_meter_autorange;

    localparam int CHANNELS = 2;
    localparam int DIGITS   = 3;
    localparam int GATE_CYC = 10000;
    localparam int SCAN_DIV = 4;
    localparam int CH_W     = 2;

    logic                clock = 1'b0;
    logic                reset;
    logic [CHANNELS-1:0] clock_text;
    logic [CH_W-1:0]     ch_sel;
    logic                valid;
    logic [1:0]          range;
    logic                overflow;
    logic [DIGITS-1:0]   N;
    logic [7:0]          L;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [11:0] val;
        logic [1:0]  rng;
        logic        ovf;
        bit          chk_val;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];

    int half[CHANNELS];
    bit restart[CHANNELS];

    freq_meter_autorange #(
        .CHANNELS(CHANNELS),
        .DIGITS  (DIGITS),
        .GATE_CYC(GATE_CYC),
        .SCAN_DIV(SCAN_DIV),
        .CH_W    (CH_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .clock_text(clock_text),
        .ch_sel    (ch_sel),
        .valid     (valid),
        .range     (range),
        .overflow  (overflow),
        .N         (N),
        .L         (L)
    );

    always #10 clock = ~clock;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_period(input int ch, input int h);
        half[ch]    = h;
        restart[ch] = 1'b1;
    endtask

    task automatic push(input logic [11:0] v, input logic [1:0] r, input logic o,
                        input bit cv, input string tag);
        exp_t e;
        e.val = v; e.rng = r; e.ovf = o; e.chk_val = cv;
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    function automatic int digit_pos(input logic [DIGITS-1:0] n);
        logic [DIGITS-1:0] pat;
        int pos = -1;
        for (int d = 0; d < DIGITS; d++) begin
            pat = ~(DIGITS'(1) << d);
            if (n === pat) pos = d;
        end
        return pos;
    endfunction

    task automatic check_display(input logic [11:0] v, input string tag);
        bit seen[DIGITS];
        int pos;
        for (int d = 0; d < DIGITS; d++) seen[d] = 1'b0;
        for (int i = 0; i < 2 * DIGITS * SCAN_DIV; i++) begin
            @(negedge clock);
            pos = digit_pos(N);
            check({tag, "_N_onehot"}, 32'(pos >= 0), 32'd1);
            if (pos >= 0) begin
                seen[pos] = 1'b1;
                check({tag, "_L"}, 32'(L), 32'(seg7(v[4*pos +: 4])));
            end
        end
        check({tag, "_scan_all"}, 32'(seen[0] & seen[1] & seen[2]), 32'd1);
    endtask

    task automatic wait_valid(input int maxc, output int waited);
        exp_t  e;
        string t;
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (valid !== 1'b1 && waited < maxc);
        e = sb.pop_front();
        t = sb_tag.pop_front();
        check({t, "_valid"}, 32'(valid), 32'd1);
        if (valid === 1'b1) begin
            check({t, "_range"}, 32'(range), 32'(e.rng));
            check({t, "_overflow"}, 32'(overflow), 32'(e.ovf));
            if (e.chk_val) check_display(e.val, t);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_range"}, 32'(range), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_N"}, 32'(N), 32'h6);
        check({tag, "_L"}, 32'(L), 32'hC0);
    endtask

    // Square-wave generators: period is 2*half clock cycles; a restart
    // drops the line low and begins a fresh period
    initial begin
        int c[CHANNELS];
        clock_text = '0;
        for (int k = 0; k < CHANNELS; k++) c[k] = 0;
        forever begin
            @(negedge clock);
            for (int k = 0; k < CHANNELS; k++) begin
                if (restart[k]) begin
                    restart[k]    = 1'b0;
                    clock_text[k] = 1'b0;
                    c[k]          = 0;
                end else if (half[k] > 0) begin
                    c[k]++;
                    if (c[k] >= half[k]) begin
                        c[k]          = 0;
                        clock_text[k] = ~clock_text[k];
                    end
                end
            end
        end
    end

    initial begin
        #(20 * 98000);
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int pos;
        reset  = 1'b1;
        ch_sel = '0;
        half[0] = 100; half[1] = 10;
        restart[0] = 1'b0; restart[1] = 1'b0;
        tick(3);
        check_reset_outputs("rst0");
        reset = 1'b0;

        // 1: 200-cycle period -> 50 edges per 10000-cycle gate
        push(12'h050, 2'd0, 1'b0, 1'b1, "t1");
        wait_valid(10100, w);
        check("t1_latency", 32'(w >= 9995 && w <= 10010), 32'd1);

        // 2: 4-cycle period overflows range 0, then 250 at range 1
        set_period(0, 2);
        push(12'h250, 2'd1, 1'b0, 1'b1, "t2");
        wait_valid(12000, w);

        // 3: slow input mid-gate; mixed gate stays range 1, then 005 drops
        // the range, then 050 at range 0
        tick(475);
        set_period(0, 100);
        push(12'h000, 2'd1, 1'b0, 1'b0, "t3_mixed");
        push(12'h005, 2'd0, 1'b0, 1'b1, "t3_r1");
        push(12'h050, 2'd0, 1'b0, 1'b1, "t3_r0");
        wait_valid(1100, w);
        wait_valid(1100, w);
        wait_valid(10100, w);

        // 4: switch to channel 1 (20-cycle period -> 500)
        ch_sel = 2'd1;
        tick(1);
        pos = digit_pos(N);
        check("t4_sw_N_onehot", 32'(pos >= 0), 32'd1);
        if (pos == 0)      check("t4_sw_L", 32'(L), 32'hC0);
        else if (pos == 1) check("t4_sw_L", 32'(L), 32'hC0);
        else if (pos == 2) check("t4_sw_L", 32'(L), 32'h92);
        check("t4_sw_range", 32'(range), 32'd0);
        check_display(12'h500, "t4_disp");
        push(12'h500, 2'd0, 1'b0, 1'b1, "t4");
        wait_valid(10100, w);

        // 6: out-of-range select shows channel 0
        ch_sel = 2'd3;
        tick(1);
        check("t6_range", 32'(range), 32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);
        check_display(12'h050, "t6_disp");
        push(12'h050, 2'd0, 1'b0, 1'b1, "t6");
        wait_valid(10100, w);

        // 5: reset mid-gate, then a full range-0 gate
        ch_sel = 2'd0;
        tick(5970);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_reset_outputs("t5_rst");
        end
        reset = 1'b0;
        push(12'h050, 2'd0, 1'b0, 1'b1, "t5");
        wait_valid(10100, w);
        check("t5_latency", 32'(w >= 9995 && w <= 10010), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
